// File: rtl/systolic_pkg.sv
// Shared constants, state encoding and lane-window helper for the 4x4 systolic operand feeder.
package systolic_pkg;

    localparam int N                = 4;
    localparam int DEF_DATA_WIDTH   = 16;
    localparam int DEF_WEIGHT_WIDTH = 8;
    localparam int FEED_CYCLES      = 2 * N - 1;
    localparam int DRAIN_CYCLES     = N - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    // Lane idx carries a real operand while step t lies inside its skewed window.
    function automatic logic lane_active(input logic [2:0] t, input int idx);
        return (int'(t) >= idx) && (int'(t) <= idx + N - 1);
    endfunction

endpackage

// File: rtl/systolic_operand_buffer.sv
// Dual 4x4 operand register file (A data, B weights): one write port, combinational full read.
module systolic_operand_buffer
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_wr_en,
    input  logic                    i_wr_sel,
    input  logic [1:0]              i_wr_row,
    input  logic [1:0]              i_wr_col,
    input  logic [DATA_WIDTH-1:0]   i_wr_data,
    output logic [DATA_WIDTH-1:0]   o_a [N][N],
    output logic [WEIGHT_WIDTH-1:0] o_b [N][N]
);

    logic [DATA_WIDTH-1:0]   r_a [N][N];
    logic [WEIGHT_WIDTH-1:0] r_b [N][N];

    // NOTE: this storage is a flop array, not a RAM macro, so clearing it on reset is legal and expected.
    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    r_a[r][c] <= '0;
                    r_b[r][c] <= '0;
                end
            end
        end else if (i_wr_en) begin
            if (i_wr_sel) begin
                r_b[i_wr_row][i_wr_col] <= i_wr_data[WEIGHT_WIDTH-1:0];
            end else begin
                r_a[i_wr_row][i_wr_col] <= i_wr_data;
            end
        end
    end

    assign o_a = r_a;
    assign o_b = r_b;

endmodule

// File: rtl/systolic_feeder_4x4.sv
// Sequences a 4x4 output-stationary systolic run: optional accumulator clear, skewed A/B feed, drain, done.
module systolic_feeder_4x4
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic                    wr_sel,
    input  logic [1:0]              wr_row,
    input  logic [1:0]              wr_col,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    start,
    input  logic                    accumulate,
    output logic                    busy,
    output logic                    done,
    output logic                    arr_enable,
    output logic                    arr_clear_accum,
    output logic [DATA_WIDTH-1:0]   data_out_0,
    output logic [DATA_WIDTH-1:0]   data_out_1,
    output logic [DATA_WIDTH-1:0]   data_out_2,
    output logic [DATA_WIDTH-1:0]   data_out_3,
    output logic                    data_valid_0,
    output logic                    data_valid_1,
    output logic                    data_valid_2,
    output logic                    data_valid_3,
    output logic [WEIGHT_WIDTH-1:0] weight_out_0,
    output logic [WEIGHT_WIDTH-1:0] weight_out_1,
    output logic [WEIGHT_WIDTH-1:0] weight_out_2,
    output logic [WEIGHT_WIDTH-1:0] weight_out_3,
    output logic                    weight_valid_0,
    output logic                    weight_valid_1,
    output logic                    weight_valid_2,
    output logic                    weight_valid_3
);

    state_t                  r_state, w_state_nxt;
    logic [2:0]              r_t, w_t_nxt;
    logic                    w_wr_allow;
    logic [DATA_WIDTH-1:0]   w_a [N][N];
    logic [WEIGHT_WIDTH-1:0] w_b [N][N];

    logic [DATA_WIDTH-1:0]   r_data [N];
    logic [WEIGHT_WIDTH-1:0] r_weight [N];
    logic [N-1:0]            r_dv, r_wv;
    logic                    r_run, r_done, r_clr;

    logic [DATA_WIDTH-1:0]   w_data_nxt [N];
    logic [WEIGHT_WIDTH-1:0] w_weight_nxt [N];
    logic [N-1:0]            w_dv_nxt, w_wv_nxt;
    logic                    w_run_nxt, w_done_nxt, w_clr_nxt;

    assign w_wr_allow = wr_en && (r_state == S_IDLE);

    systolic_operand_buffer #(
        .DATA_WIDTH  (DATA_WIDTH),
        .WEIGHT_WIDTH(WEIGHT_WIDTH)
    ) u_buffer (
        .clk      (clk),
        .rst      (rst),
        .i_wr_en  (w_wr_allow),
        .i_wr_sel (wr_sel),
        .i_wr_row (wr_row),
        .i_wr_col (wr_col),
        .i_wr_data(wr_data),
        .o_a      (w_a),
        .o_b      (w_b)
    );

    // Outputs are decoded from the next state/step and registered, so they line up with r_state.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        w_state_nxt = r_state;
        w_t_nxt     = r_t;
        w_dv_nxt    = '0;
        w_wv_nxt    = '0;
        for (int i = 0; i < N; i++) begin
            w_data_nxt[i]   = '0;
            w_weight_nxt[i] = '0;
        end

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = accumulate ? S_FEED : S_CLEAR;
                    w_t_nxt     = '0;
                end
            end
            S_CLEAR, S_FEED: begin
                if (r_t == 3'(FEED_CYCLES - 1)) begin
                    w_state_nxt = (r_state == S_CLEAR) ? S_FEED : S_DRAIN;
                    w_t_nxt     = '0;
                end else begin
                    w_t_nxt = r_t + 3'd1;
                end
            end
            S_DRAIN: begin
                if (r_t == 3'(DRAIN_CYCLES - 1)) begin
                    w_state_nxt = S_DONE;
                    w_t_nxt     = '0;
                end else begin
                    w_t_nxt = r_t + 3'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_t_nxt     = '0;
            end
        endcase

        w_run_nxt  = (w_state_nxt == S_CLEAR) || (w_state_nxt == S_FEED) || (w_state_nxt == S_DRAIN);
        w_done_nxt = (w_state_nxt == S_DONE);
        w_clr_nxt  = (w_state_nxt == S_CLEAR);

        // Row lane i carries A[i][t-i]; column lane j carries B[t-j][j]; CLEAR sends one zero token each.
        for (int i = 0; i < N; i++) begin
            if (w_state_nxt == S_CLEAR) begin
                w_dv_nxt[i] = (w_t_nxt == 3'(i));
                w_wv_nxt[i] = (w_t_nxt == 3'(i));
            end else if (w_state_nxt == S_FEED && lane_active(w_t_nxt, i)) begin
                w_dv_nxt[i]     = 1'b1;
                w_wv_nxt[i]     = 1'b1;
                w_data_nxt[i]   = w_a[i][2'(w_t_nxt - 3'(i))];
                w_weight_nxt[i] = w_b[2'(w_t_nxt - 3'(i))][i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_t     <= '0;
            r_dv    <= '0;
            r_wv    <= '0;
            r_run   <= 1'b0;
            r_done  <= 1'b0;
            r_clr   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_data[i]   <= '0;
                r_weight[i] <= '0;
            end
        end else begin
            r_state  <= w_state_nxt;
            r_t      <= w_t_nxt;
            r_dv     <= w_dv_nxt;
            r_wv     <= w_wv_nxt;
            r_run    <= w_run_nxt;
            r_done   <= w_done_nxt;
            r_clr    <= w_clr_nxt;
            r_data   <= w_data_nxt;
            r_weight <= w_weight_nxt;
        end
    end

    assign busy            = r_run;
    assign arr_enable      = r_run;
    assign done            = r_done;
    assign arr_clear_accum = r_clr;

    assign data_out_0 = r_data[0];
    assign data_out_1 = r_data[1];
    assign data_out_2 = r_data[2];
    assign data_out_3 = r_data[3];
    assign {data_valid_3, data_valid_2, data_valid_1, data_valid_0} = r_dv;

    assign weight_out_0 = r_weight[0];
    assign weight_out_1 = r_weight[1];
    assign weight_out_2 = r_weight[2];
    assign weight_out_3 = r_weight[3];
    assign {weight_valid_3, weight_valid_2, weight_valid_1, weight_valid_0} = r_wv;

endmodule
